// File: rtl/pong_text_pkg.sv
// Shared constants for the credits banner: FSM state codes and banner geometry.
package pong_text_pkg;

  localparam int BANNER_W = 128;
  localparam int BANNER_H = 16;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SCROLL_IN  = 3'd1;
  localparam logic [2:0] ST_HOLD       = 3'd2;
  localparam logic [2:0] ST_SCROLL_OUT = 3'd3;
  localparam logic [2:0] ST_FINISH     = 3'd4;

  // Banner is drawn only while it is moving or parked on screen.
  function automatic logic is_rendering(input logic [2:0] st);
    return (st == ST_SCROLL_IN) || (st == ST_HOLD) || (st == ST_SCROLL_OUT);
  endfunction

endpackage

// File: rtl/text_pixel_pipe.sv
// Two-stage pixel pipeline: stage 1 registers the font address, stage 2 lines
// the bit index and window flag up with the font ROM's registered read data.
module text_pixel_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_win,
  input  logic [6:0]  char_code,
  input  logic [3:0]  glyph_row,
  input  logic [2:0]  bit_idx,
  input  logic [7:0]  font_word,
  output logic [10:0] font_addr,
  output logic        text_on
);

  logic [1:0] vld_pipe;
  logic [2:0] bit_s1;
  logic [2:0] bit_s2;

  // Stage 1 captures address/bit/flag; stage 2 delays bit/flag one more clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      font_addr <= '0;
      bit_s1    <= '0;
      bit_s2    <= '0;
      vld_pipe  <= '0;
    end else begin
      font_addr <= {char_code, glyph_row};
      bit_s1    <= bit_idx;
      bit_s2    <= bit_s1;
      vld_pipe  <= {vld_pipe[0], in_win};
    end
  end

  // Bit 7 of the font row is the leftmost pixel.
  assign text_on = vld_pipe[1] & font_word[3'd7 - bit_s2];

endmodule

// File: rtl/credits_scroll_ctrl.sv
// Credits banner controller: scrolls a 128x16 text banner in from the right,
// holds it centred for a number of frames, scrolls it out to the left.
module credits_scroll_ctrl
  import pong_text_pkg::*;
#(
  parameter int TEXT_Y      = 32,
  parameter int START_X     = 640,
  parameter int CENTER_X    = 256,
  parameter int END_X       = -128,
  parameter int HOLD_FRAMES = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [6:0]  char_code,
  input  logic [7:0]  font_word,
  output logic [7:0]  char_xy,
  output logic [10:0] font_addr,
  output logic        text_on,
  output logic        busy,
  output logic        done
);

  localparam logic signed [10:0] START_BX  = 11'(START_X);
  localparam logic signed [10:0] CENTER_BX = 11'(CENTER_X);
  localparam logic signed [10:0] END_BX    = 11'(END_X);
  localparam logic signed [10:0] TEXT_Y11  = 11'(TEXT_Y);
  localparam logic signed [10:0] W_LAST    = 11'(BANNER_W - 1);
  localparam logic signed [10:0] H_LAST    = 11'(BANNER_H - 1);
  localparam logic [15:0]        HOLD_N    = 16'(HOLD_FRAMES);

  logic [2:0]         state;
  logic signed [10:0] bx;
  logic signed [10:0] bx_dec;
  logic [15:0]        hold_cnt;
  logic [15:0]        hold_inc;

  assign bx_dec   = bx - 11'sd1;
  assign hold_inc = hold_cnt + 16'd1;

  // Sequencer: bx and the hold counter only move on frame_tick so the banner
  // stays still for the whole visible frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      bx       <= START_BX;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state    <= ST_SCROLL_IN;
          bx       <= START_BX;
          hold_cnt <= '0;
        end
        ST_SCROLL_IN: if (frame_tick) begin
          bx <= bx_dec;
          if (bx_dec == CENTER_BX) state <= ST_HOLD;
        end
        ST_HOLD: if (frame_tick) begin
          hold_cnt <= hold_inc;
          if (hold_inc == HOLD_N) state <= ST_SCROLL_OUT;
        end
        ST_SCROLL_OUT: if (frame_tick) begin
          bx <= bx_dec;
          if (bx_dec == END_BX) state <= ST_FINISH;
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FINISH);

  // Banner-relative coordinates. 11-bit signed range covers every
  // pixel_x - bx combination without aliasing back into the window.
  logic signed [10:0] rel_x;
  logic signed [10:0] rel_y;
  logic               in_win;

  assign rel_x = $signed({1'b0, pixel_x}) - bx;
  assign rel_y = $signed({1'b0, pixel_y}) - TEXT_Y11;

  // Window test; off-screen banner columns simply never match a pixel.
  always_comb begin
    in_win = video_on && is_rendering(state) &&
             (rel_x >= 11'sd0) && (rel_x <= W_LAST) &&
             (rel_y >= 11'sd0) && (rel_y <= H_LAST);
  end

  assign char_xy = in_win ? {4'h0, rel_x[6:3]} : 8'h00;

  text_pixel_pipe u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_win    (in_win),
    .char_code (char_code),
    .glyph_row (rel_y[3:0]),
    .bit_idx   (rel_x[2:0]),
    .font_word (font_word),
    .font_addr (font_addr),
    .text_on   (text_on)
  );

endmodule

// File: doc/credits_scroll_ctrl.md
CREDITS_SCROLL_CTRL -- requirements
Module: credits_scroll_ctrl

Interface
REQ-001 Parameter TEXT_Y, default 32: top pixel row of the 16-row banner.
REQ-002 Parameter START_X, default 640: banner left-edge x at scroll start.
REQ-003 Parameter CENTER_X, default 256: banner left-edge x during hold.
REQ-004 Parameter END_X, default -128: banner left-edge x at which scroll-out ends; signed.
REQ-005 Parameter HOLD_FRAMES, default 120: frames held at CENTER_X.
REQ-006 clk  input  1  system clock; the block's only clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 video_on  input  1  active-video flag from VGA sync.
REQ-009 pixel_x  input  10  current pixel column.
REQ-010 pixel_y  input  10  current pixel row.
REQ-011 frame_tick  input  1  one-clock pulse per frame at start of vertical retrace.
REQ-012 start  input  1  one-clock request to run one credits sequence.
REQ-013 char_code  input  7  ASCII code returned combinationally by the 16x1 credits char ROM.
REQ-014 font_word  input  8  font ROM row data; 1-clock registered read latency; bit 7 = leftmost pixel.
REQ-015 char_xy  output  8  char ROM address; [7:4] = 0 (row), [3:0] = column 0..15.
REQ-016 font_addr  output  11  font ROM address = {char_code, glyph row[3:0]}.
REQ-017 text_on  output  1  banner pixel lit at the pixel sampled 2 clocks earlier.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-clock pulse when a sequence completes.

Function
REQ-020 FSM states IDLE, SCROLL_IN, HOLD, SCROLL_OUT, FINISH.
REQ-021 IDLE: start=1 -> SCROLL_IN, bx loaded with START_X, hold counter cleared; other states ignore start.
REQ-022 bx is 11-bit signed; it changes only on frame_tick, so the banner is static within a frame.
REQ-023 SCROLL_IN: each frame_tick decrements bx by 1; the tick on which bx becomes CENTER_X -> HOLD.
REQ-024 HOLD: each frame_tick increments the hold counter; the tick bringing it to HOLD_FRAMES -> SCROLL_OUT.
REQ-025 SCROLL_OUT: each frame_tick decrements bx by 1; the tick on which bx becomes END_X -> FINISH.
REQ-026 FINISH lasts exactly one clock with done=1, then -> IDLE.
REQ-027 start and frame_tick in the same IDLE cycle: start is accepted; first decrement occurs on the next frame_tick.
REQ-028 Window: rel_x = pixel_x - bx (11-bit signed), rel_y = pixel_y - TEXT_Y; in-window iff 0<=rel_x<=127, 0<=rel_y<=15, video_on=1, and state is SCROLL_IN, HOLD or SCROLL_OUT.
REQ-029 char_xy = {4'h0, rel_x[6:3]} combinationally from the current pixel; 0 when outside the window.
REQ-030 Stage 1 (registered): font_addr = {char_code, rel_y[3:0]}, bit index rel_x[2:0], in-window flag.
REQ-031 Stage 2: bit index and flag delayed one more clock to align with font_word.
REQ-032 text_on = stage-2 flag AND font_word[7 - stage-2 bit index]; total latency 2 clocks from pixel_x/pixel_y.
REQ-033 Partially visible banner (bx < 0 or bx + 127 > 639): only on-screen columns render; no wrap-around.

Reset
REQ-034 reset=1 at any clock edge: state IDLE, bx = START_X, hold counter 0, pipeline flags 0.
REQ-035 Outputs during and after reset: text_on=0, busy=0, done=0, font_addr=0; char_xy=0.
REQ-036 Reset mid-sequence aborts with no done pulse; start on the first cycle after reset release is accepted.

Structure
REQ-037 State enumeration, banner width (128) and height (16) constants live in shared package pong_text_pkg.
REQ-038 The stage-1/stage-2 pixel pipeline (REQ-030..032) is sub-module text_pixel_pipe; FSM and bx counter stay in the top.

Verification
REQ-039 reset, start pulse, count frame_ticks -> busy high; bx hits 256 after 384 ticks, HOLD for 120 ticks, done pulse after 384 more ticks (888 total).
REQ-040 start during HOLD -> ignored; sequence timing unchanged; exactly one done pulse.
REQ-041 HOLD, pixel_y=32, pixel_x=256..383, glyph model for "     CREDITS    " -> char_xy 0..15 stepping every 8 pixels; text_on matches model with 2-clock lag.
REQ-042 video_on=0 or pixel_y=48 during HOLD -> text_on=0 for all pixel_x.
REQ-043 reset asserted in SCROLL_OUT with bx=-60 -> next clock busy=0, text_on=0, no done; new start reloads bx=640.
REQ-044 start and frame_tick in the same cycle -> bx stays 640 until next frame_tick, then 639.
